// File: rtl/instr_encoder_loader.sv
// Loads RV32I lw/sw/R-type/beq words into imem from decoded fields.
// One command per two cycles: accept, then a single imem write.
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [2:0]        cmd_funct3,
  input  logic              cmd_funct7b5,
  input  logic [12:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t state, state_nx;
  logic   last_q;
  logic   accept;
  logic   misal;
  logic [ADDR_W:0] count_inc;

  function automatic logic [31:0] encode(
    input logic [1:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [12:0] imm
  );
    logic [31:0] w;
    unique case (kind)
      2'b00: w = {imm[11:0], rs1, f3, rd, 7'b0000011};
      2'b01: w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      2'b10: w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      2'b11: w = {imm[12], imm[10:5], rs2, rs1, f3,
                  imm[4:1], imm[11], 7'b1100011};
    endcase
    return w;
  endfunction

  assign cmd_ready = (state == ACCEPT);
  // A pending write is suppressed in the very cycle reset arrives.
  assign imem_we   = (state == WRITE) && !rst;
  assign busy      = (state == ACCEPT) || (state == WRITE);
  assign done      = (state == DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign misal     = (cmd_kind == 2'b11) && cmd_imm[0];
  assign count_inc = count + 1'b1;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = ACCEPT;
      end
      ACCEPT: begin
        if (accept) begin
          if (!misal)        state_nx = WRITE;
          else if (cmd_last) state_nx = DONE;
        end
      end
      WRITE: begin
        if (last_q || count_inc == CAP) state_nx = DONE;
        else                            state_nx = ACCEPT;
      end
      DONE: begin
        if (start) state_nx = ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_waddr <= BASE;
      imem_wdata <= '0;
      count      <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            imem_waddr <= BASE;
            count      <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
          end
        end
        ACCEPT: begin
          if (accept) begin
            last_q <= cmd_last;
            if (misal) err <= 1'b1;
            else imem_wdata <= encode(cmd_kind, cmd_rd, cmd_rs1,
                                      cmd_rs2, cmd_funct3,
                                      cmd_funct7b5, cmd_imm);
          end
        end
        WRITE: begin
          imem_waddr <= imem_waddr + 1'b1;
          count      <= count_inc;
          if (count_inc == CAP) full <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed scoreboard bench for instr_encoder_loader (ADDR_W=2).
// Expected imem writes are queued at accept and popped on imem_we.
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_kind;
  logic [4:0]    cmd_rd;
  logic [4:0]    cmd_rs1;
  logic [4:0]    cmd_rs2;
  logic [2:0]    cmd_funct3;
  logic          cmd_funct7b5;
  logic [12:0]   cmd_imm;
  logic          cmd_last;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          full;
  logic          err;
  logic [AW:0]   count;

  int errors = 0;
  int checks = 0;
  logic [AW+31:0] q[$];
  logic [AW-1:0]  exp_addr;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_funct3(cmd_funct3), .cmd_funct7b5(cmd_funct7b5),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .full(full), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic [AW+31:0] e;
    if (imem_we) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 64'(imem_wdata), 64'hdead);
      end else begin
        e = q.pop_front();
        chk("waddr", 64'(imem_waddr), 64'(e[AW+31:32]));
        chk("wdata", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0]  kind,
                      input logic [4:0]  rd,
                      input logic [4:0]  rs1,
                      input logic [4:0]  rs2,
                      input logic [2:0]  f3,
                      input logic        f7,
                      input logic [12:0] imm,
                      input logic        last,
                      input logic        wr,
                      input logic [31:0] word);
    int n;
    cmd_kind = kind; cmd_rd = rd; cmd_rs1 = rs1;
    cmd_rs2 = rs2; cmd_funct3 = f3; cmd_funct7b5 = f7;
    cmd_imm = imm; cmd_last = last; cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      mon();
      if (cmd_ready) break;
      n++;
      if (n > 20) begin
        chk("accept_timeout", 64'(n), 64'(0));
        cmd_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    if (wr) begin
      q.push_back({exp_addr, word});
      exp_addr = exp_addr + 1'b1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_rd = 5'h1f; cmd_rs1 = 5'h1f; cmd_imm = 13'h1555;
    if (wr) begin
      @(negedge clk);
      mon();
      chk("ready_in_write", 64'(cmd_ready), 64'(0));
      chk("write_latency", 64'(q.size()), 64'(0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'(0));
    chk({tag, "_busy"},  64'(busy),  64'(0));
    chk({tag, "_done"},  64'(done),  64'(0));
    chk({tag, "_full"},  64'(full),  64'(0));
    chk({tag, "_err"},   64'(err),   64'(0));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_waddr"}, 64'(imem_waddr), 64'(0));
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmd_valid = 1'b0;
    cmd_kind = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_funct3 = '0; cmd_funct7b5 = 1'b0; cmd_imm = '0;
    cmd_last = 1'b0; exp_addr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_we", 64'(imem_we), 64'(0));
    @(posedge clk); #1;

    // single lw session
    pulse_start();
    chk("accept_busy", 64'(busy), 64'(1));
    exp_addr = '0;
    send(2'b00, 5'd6, 5'd9, 5'd0, 3'b010, 1'b0,
         13'h0ffc, 1'b1, 1'b1, 32'hFFC4A303);
    chk("lw_done", 64'(done), 64'(1));
    chk("lw_count", 64'(count), 64'(1));
    chk("lw_busy", 64'(busy), 64'(0));

    // sw, add, beq
    pulse_start();
    exp_addr = '0;
    send(2'b01, 5'd0, 5'd9, 5'd6, 3'b010, 1'b0,
         13'd8, 1'b0, 1'b1, 32'h0064A423);
    chk("sw_ready_back", 64'(cmd_ready), 64'(1));
    send(2'b10, 5'd2, 5'd3, 5'd4, 3'b000, 1'b0,
         13'd0, 1'b0, 1'b1, 32'h00418133);
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0,
         13'd8, 1'b1, 1'b1, 32'h00208463);
    chk("s2_done", 64'(done), 64'(1));
    chk("s2_count", 64'(count), 64'(3));
    chk("s2_ready", 64'(cmd_ready), 64'(0));

    // misaligned beq, then lw
    pulse_start();
    exp_addr = '0;
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0,
         13'd9, 1'b0, 1'b0, 32'h0);
    chk("misal_err", 64'(err), 64'(1));
    chk("misal_ready", 64'(cmd_ready), 64'(1));
    chk("misal_count", 64'(count), 64'(0));
    send(2'b00, 5'd6, 5'd9, 5'd0, 3'b010, 1'b0,
         13'h0ffc, 1'b1, 1'b1, 32'hFFC4A303);
    chk("misal_lw_count", 64'(count), 64'(1));
    chk("misal_err_held", 64'(err), 64'(1));
    chk("misal_done", 64'(done), 64'(1));

    // restart from DONE clears status
    pulse_start();
    chk("restart_count", 64'(count), 64'(0));
    chk("restart_done", 64'(done), 64'(0));
    chk("restart_err", 64'(err), 64'(0));
    chk("restart_ready", 64'(cmd_ready), 64'(1));
    exp_addr = '0;
    send(2'b10, 5'd5, 5'd6, 5'd7, 3'b000, 1'b1,
         13'd0, 1'b0, 1'b1, 32'h407302B3);
    // start during ACCEPT is ignored
    pulse_start();
    chk("acc_start_count", 64'(count), 64'(1));
    chk("acc_start_waddr", 64'(imem_waddr), 64'(1));
    send(2'b11, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0,
         13'h1ffc, 1'b1, 1'b1, 32'hFE001EE3);
    chk("acc_start_final", 64'(count), 64'(2));

    // fill capacity without last
    pulse_start();
    exp_addr = '0;
    send(2'b01, 5'd0, 5'd2, 5'd1, 3'b010, 1'b0,
         13'h1ffc, 1'b0, 1'b1, 32'hFE112E23);
    send(2'b00, 5'd6, 5'd9, 5'd0, 3'b010, 1'b0,
         13'h0ffc, 1'b0, 1'b1, 32'hFFC4A303);
    send(2'b10, 5'd2, 5'd3, 5'd4, 3'b000, 1'b0,
         13'd0, 1'b0, 1'b1, 32'h00418133);
    chk("pre_full", 64'(full), 64'(0));
    send(2'b10, 5'd5, 5'd6, 5'd7, 3'b000, 1'b1,
         13'd0, 1'b0, 1'b1, 32'h407302B3);
    chk("full_flag", 64'(full), 64'(1));
    chk("full_done", 64'(done), 64'(1));
    chk("full_count", 64'(count), 64'(4));
    chk("full_wrap", 64'(imem_waddr), 64'(0));
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("full_ready", 64'(cmd_ready), 64'(0));
    end
    cmd_valid = 1'b0;
    chk("full_count_hold", 64'(count), 64'(4));

    // reset during the WRITE cycle of the second command
    pulse_start();
    exp_addr = '0;
    send(2'b01, 5'd0, 5'd9, 5'd6, 3'b010, 1'b0,
         13'd8, 1'b0, 1'b1, 32'h0064A423);
    cmd_kind = 2'b10; cmd_rd = 5'd2; cmd_rs1 = 5'd3;
    cmd_rs2 = 5'd4; cmd_funct3 = 3'b000; cmd_funct7b5 = 1'b0;
    cmd_imm = '0; cmd_last = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    chk("rst_pre_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_we_dropped", 64'(imem_we), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("midrst");
    pulse_start();
    exp_addr = '0;
    send(2'b00, 5'd6, 5'd9, 5'd0, 3'b010, 1'b0,
         13'h0ffc, 1'b1, 1'b1, 32'hFFC4A303);
    chk("post_rst_count", 64'(count), 64'(1));

    cyc();
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential inverse of the main control decoder. It takes decoded instruction fields (kind, registers, funct, immediate) over a valid/ready command interface.
- It assembles the RV32I instruction words for lw, sw, R-type and beq, and writes them one by one into consecutive words of instruction memory.
- Used by the bench and boot logic to load programs into the single-cycle core's imem without a hex file.

Parameters:
- ADDR_W, 6, width of the imem word address; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first write after start.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session at BASE_ADDR.
- cmd_valid  input  1  command fields are valid.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_kind  input  2  00 lw, 01 sw, 10 R-type, 11 beq.
- cmd_rd  input  5  destination register (lw, R-type).
- cmd_rs1  input  5  source register 1.
- cmd_rs2  input  5  source register 2 (sw, R-type, beq).
- cmd_funct3  input  3  funct3 field.
- cmd_funct7b5  input  1  bit 30 for R-type; other funct7 bits are 0.
- cmd_imm  input  13  signed immediate. lw/sw use [11:0]. beq uses [12:1], and [0] must be 0.
- cmd_last  input  1  this command is the final one of the session.
- imem_we  output  1  imem write strobe.
- imem_waddr  output  ADDR_W  imem word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  high in ACCEPT or WRITE.
- done  output  1  session finished; held until start or rst.
- full  output  1  session ended because capacity was reached.
- err  output  1  sticky: a misaligned beq immediate was rejected.
- count  output  ADDR_W+1  number of words written this session.

Behaviour:
- Reset (rst=1 at the edge):
  - State goes to IDLE.
  - cmd_ready, imem_we, busy, done, full and err go to 0; count goes to 0.
  - imem_waddr goes to BASE_ADDR and imem_wdata to 0.
  - Reset wins over every other input, including mid-session. A write registered but not yet issued is dropped.
- States:
  - IDLE: cmd_ready=0. start → ACCEPT, with waddr=BASE_ADDR, count=0, err=0.
  - ACCEPT: cmd_ready=1. On cmd_valid&cmd_ready, fields and cmd_last are registered and the word is encoded → WRITE.
  - WRITE: cmd_ready=0. imem_we=1 for exactly this cycle with the registered waddr and wdata. At the end of the cycle waddr and count increment.
    - → DONE if the captured last=1, or if count reaches 2^ADDR_W (this also sets full=1).
    - → ACCEPT otherwise.
  - DONE: done=1 and cmd_ready=0. start → ACCEPT, with count, full, err and done cleared and waddr=BASE_ADDR.
- start in ACCEPT or WRITE is ignored.
- Latency and throughput: a command accepted in cycle N is written in cycle N+1. Maximum throughput is one command per 2 cycles.
- Encodings (bits high to low):
  - lw: imm[11:0], rs1, funct3, rd, 0000011.
  - sw: imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011.
  - R-type: 0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011.
  - beq: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011.
- Misaligned beq (cmd_imm[0]=1):
  - The command is still accepted (handshake completes) and err is set.
  - No write occurs: imem_we stays 0 and waddr and count are unchanged.
  - Next state is DONE if last=1, else ACCEPT.
- imem_waddr wraps modulo 2^ADDR_W. With BASE_ADDR≠0 the session still stops after 2^ADDR_W writes.
- imem_wdata holds its value outside WRITE.
- The command fields are sampled only at the accept edge. Changes to them while cmd_ready=0 have no effect.

Test Plan:
- Reset, then start, then lw (kind 00, rd=6, rs1=9, funct3=010, imm=0xFFC) with last=1 → next cycle imem_we=1, waddr=0, wdata=0xFFC4A303; then done=1, count=1.
- start, then sw (rs2=6, rs1=9, funct3=010, imm=8), then add (rd=2, rs1=3, rs2=4, funct3=0, funct7b5=0), then beq (rs1=1, rs2=2, imm=8) with last on the third → writes 0x0064A423 at 0, 0x00418133 at 1, 0x00208463 at 2; cmd_ready toggles 1,0,1,0,1,0; done=1, count=3.
- beq with imm=9 then lw with last=1 → err=1, no write for beq; lw is written at waddr=0; count=1.
- ADDR_W=2, cmd_valid held high with last=0 → 4 writes at 0..3, then full=1 and done=1, cmd_ready=0 thereafter.
- Assert rst in the WRITE cycle of the second command → imem_we=0 that cycle; all outputs at reset values; a later start restarts at BASE_ADDR.
- start pulsed during ACCEPT → no effect on waddr or count; start in DONE → count=0, done=0, err=0, cmd_ready=1 next cycle.
